// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

  // Loader FSM states, in stream order.
  typedef enum logic [2:0] {
    ST_LEN0 = 3'd0,
    ST_LEN1 = 3'd1,
    ST_DATA = 3'd2,
    ST_CHK  = 3'd3,
    ST_RUN  = 3'd4,
    ST_ERR  = 3'd5
  } state_e;

  localparam int unsigned LEN_BYTES = 2;   // length header size in bytes
  localparam int unsigned CHK_W     = 8;   // checksum width
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned WORD_W    = 32;

endpackage

// File: rtl/imem_word_packer.sv
// Packs a byte stream little-endian into 32-bit words.
// Ports:
//   clk, rst_n     - clock, async active-low reset
//   i_clr          - synchronous clear of lane counter and partial word
//   i_byte_valid   - accept i_byte this cycle
//   i_byte         - payload byte
//   o_lane3_c      - combinational: next accepted byte completes a word
//   o_word_valid   - registered one-cycle pulse, word completed last cycle
//   o_word         - registered assembled word {b3,b2,b1,b0}
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_byte_valid,
  input  logic [BYTE_W-1:0] i_byte,
  output logic              o_lane3_c,
  output logic              o_word_valid,
  output logic [WORD_W-1:0] o_word
);

  localparam int unsigned SHIFT_W = WORD_W - BYTE_W;

  logic [1:0]         r_lane;
  logic [SHIFT_W-1:0] r_shift;

  assign o_lane3_c = (r_lane == 2'd3);

  // Bytes enter at the top and shift down, so after three bytes r_shift = {b2,b1,b0}.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lane       <= 2'd0;
      r_shift      <= '0;
      o_word_valid <= 1'b0;
      o_word       <= '0;
    end else begin
      o_word_valid <= 1'b0;
      if (i_clr) begin
        r_lane  <= 2'd0;
        r_shift <= '0;
      end else if (i_byte_valid) begin
        r_lane <= r_lane + 2'd1;
        if (o_lane3_c) begin
          o_word       <= {i_byte, r_shift};
          o_word_valid <= 1'b1;
        end else begin
          r_shift <= {i_byte, r_shift[SHIFT_W-1:BYTE_W]};
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed byte image and
// writes it into instruction memory, holding the core in reset until verified.
// Ports:
//   clk, rst_n                         - clock, async active-low reset
//   rx_valid, rx_data, rx_ready        - byte stream handshake
//   start                              - re-arm pulse (RUN/ERR only)
//   imem_we, imem_waddr, imem_wdata    - instruction-memory write port
//   core_rst                           - active-high core hold
//   load_done, load_err                - status levels
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter int unsigned ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [BYTE_W-1:0] rx_data,
  output logic              rx_ready,
  input  logic              start,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              core_rst,
  output logic              load_done,
  output logic              load_err
);

  localparam int unsigned LEN_W = LEN_BYTES * BYTE_W;
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned CMP_W = LEN_W + 1;

  state_e             r_state;
  state_e             w_next;
  logic [LEN_W-1:0]   r_len;
  logic [CNT_W-1:0]   r_wcnt;
  logic [CHK_W-1:0]   r_xor;
  logic [ADDR_W-1:0]  r_waddr;

  logic               w_hs;
  logic               w_pay;
  logic               w_lane3;
  logic               w_last_word;
  logic               w_clear;
  logic [LEN_W-1:0]   w_len_full;

  assign w_hs        = rx_valid && rx_ready;
  assign w_pay       = w_hs && (r_state == ST_DATA);
  assign w_len_full  = {rx_data, r_len[BYTE_W-1:0]};
  assign w_last_word = ((CMP_W'(r_wcnt) + CMP_W'(1)) == CMP_W'(r_len));
  assign w_clear     = start && ((r_state == ST_RUN) || (r_state == ST_ERR));
  assign imem_waddr  = r_waddr;

  imem_word_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clr        (w_clear),
    .i_byte_valid (w_pay),
    .i_byte       (rx_data),
    .o_lane3_c    (w_lane3),
    .o_word_valid (imem_we),
    .o_word       (imem_wdata)
  );

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_LEN0: if (w_hs) w_next = ST_LEN1;
      ST_LEN1: begin
        if (w_hs) begin
          if ({1'b0, w_len_full} > CMP_W'(IMEM_DEPTH)) w_next = ST_ERR;
          else if (w_len_full == '0)                  w_next = ST_CHK;
          else                                        w_next = ST_DATA;
        end
      end
      ST_DATA: if (w_pay && w_lane3 && w_last_word) w_next = ST_CHK;
      ST_CHK:  if (w_hs) w_next = (rx_data == r_xor) ? ST_RUN : ST_ERR;
      ST_RUN,
      ST_ERR:  if (start) w_next = ST_LEN0;
      default: w_next = ST_LEN0;
    endcase
  end

  // State, counters, checksum and registered status (derived from next state).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_LEN0;
      r_len     <= '0;
      r_wcnt    <= '0;
      r_xor     <= '0;
      r_waddr   <= '0;
      rx_ready  <= 1'b0;
      core_rst  <= 1'b1;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      r_state   <= w_next;
      rx_ready  <= (w_next == ST_LEN0) || (w_next == ST_LEN1) ||
                   (w_next == ST_DATA) || (w_next == ST_CHK);
      core_rst  <= (w_next != ST_RUN);
      load_done <= (w_next == ST_RUN);
      load_err  <= (w_next == ST_ERR);

      if (w_clear) begin
        r_len  <= '0;
        r_wcnt <= '0;
        r_xor  <= '0;
      end
      if (w_hs && (r_state == ST_LEN0)) r_len[BYTE_W-1:0]     <= rx_data;
      if (w_hs && (r_state == ST_LEN1)) r_len[LEN_W-1:BYTE_W] <= rx_data;
      if (w_pay) begin
        r_xor <= r_xor ^ rx_data;
        // Address is latched alongside the packer's word so both appear together.
        if (w_lane3) begin
          r_waddr <= r_wcnt[ADDR_W-1:0];
          r_wcnt  <= r_wcnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader.
module tb_imem_loader;

  logic        clk;
  logic        rst_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        start;
  logic        imem_we;
  logic [7:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic        core_rst;
  logic        load_done;
  logic        load_err;

  int n_pass  = 0;
  int n_total = 0;

  int          wr_n;
  logic [7:0]  wr_addr [0:15];
  logic [31:0] wr_data [0:15];
  logic [7:0]  stream [$];

  imem_loader #(.IMEM_DEPTH(256), .ADDR_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .start      (start),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .core_rst   (core_rst),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every memory write, sampled just after the clock edge.
  always begin
    @(posedge clk);
    #1;
    if (imem_we === 1'b1) begin
      if (wr_n < 16) begin
        wr_addr[wr_n] = imem_waddr;
        wr_data[wr_n] = imem_wdata;
      end
      wr_n = wr_n + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired got running want finished");
    $fatal(1);
  end

  // Enters and leaves on a falling edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int tries;
    for (int g = 0; g < gap; g++) begin
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      @(negedge clk);
    end
    rx_valid = 1'b1;
    rx_data  = b;
    tries    = 0;
    while (rx_ready !== 1'b1 && tries < 40) begin
      @(negedge clk);
      tries++;
    end
    if (tries >= 40) begin
      n_total++;
      $display("FAIL send_timeout got rx_ready=%b want 1", rx_ready);
    end
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic send_all(input int max_gap);
    foreach (stream[i]) send_byte(stream[i], (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap)));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_two_writes(input string tag);
    n_total++;
    if (wr_n !== 2) $display("FAIL %s.wr_count got %0d want 2", tag, wr_n); else n_pass++;
    n_total++;
    if ({wr_addr[0], wr_data[0]} !== {8'd0, 32'h0050_0093})
      $display("FAIL %s.write0 got %h/%h want 00/00500093", tag, wr_addr[0], wr_data[0]);
    else n_pass++;
    n_total++;
    if ({wr_addr[1], wr_data[1]} !== {8'd1, 32'h0000_0013})
      $display("FAIL %s.write1 got %h/%h want 01/00000013", tag, wr_addr[1], wr_data[1]);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; start = 1'b0; wr_n = 0;
    #12;
    n_total++;
    if ({rx_ready, imem_we, core_rst, load_done, load_err} !== 5'b00100)
      $display("FAIL reset.status got %b want 00100", {rx_ready, imem_we, core_rst, load_done, load_err});
    else n_pass++;
    n_total++;
    if ({imem_waddr, imem_wdata} !== 40'd0)
      $display("FAIL reset.wport got %h/%h want 0/0", imem_waddr, imem_wdata);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_total++;
    if (rx_ready !== 1'b1) $display("FAIL reset.ready_after got %b want 1", rx_ready); else n_pass++;
  endtask

  task automatic test_two_word();
    wr_n = 0;
    send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_byte(8'h93, 0); send_byte(8'h00, 0); send_byte(8'h50, 0); send_byte(8'h00, 0);
    n_total++;
    if ({imem_we, imem_waddr, imem_wdata} !== {1'b1, 8'd0, 32'h0050_0093})
      $display("FAIL two_word.latency got %b/%h/%h want 1/00/00500093", imem_we, imem_waddr, imem_wdata);
    else n_pass++;
    send_byte(8'h13, 0);
    n_total++;
    if (imem_we !== 1'b0) $display("FAIL two_word.we_pulse got %b want 0", imem_we); else n_pass++;
    send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'hD0, 0);
    check_two_writes("two_word");
    n_total++;
    if ({load_done, core_rst, rx_ready, load_err} !== 4'b1000)
      $display("FAIL two_word.status got %b want 1000", {load_done, core_rst, rx_ready, load_err});
    else n_pass++;
  endtask

  task automatic test_bad_checksum();
    pulse_start();
    wr_n = 0;
    stream = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hD1};
    send_all(0);
    check_two_writes("bad_chk");
    n_total++;
    if ({load_done, core_rst, load_err, rx_ready} !== 4'b0110)
      $display("FAIL bad_chk.status got %b want 0110", {load_done, core_rst, load_err, rx_ready});
    else n_pass++;
  endtask

  task automatic test_oversize();
    pulse_start();
    wr_n = 0;
    send_byte(8'h01, 0); send_byte(8'h01, 0);
    n_total++;
    if ({load_err, rx_ready, load_done} !== 3'b100)
      $display("FAIL oversize.status got %b want 100", {load_err, rx_ready, load_done});
    else n_pass++;
    repeat (3) @(negedge clk);
    n_total++;
    if (wr_n !== 0) $display("FAIL oversize.no_write got %0d want 0", wr_n); else n_pass++;
  endtask

  task automatic test_zero_len();
    pulse_start();
    wr_n = 0;
    stream = '{8'h00, 8'h00, 8'h00};
    send_all(0);
    repeat (2) @(negedge clk);
    n_total++;
    if (wr_n !== 0) $display("FAIL zero_len.no_write got %0d want 0", wr_n); else n_pass++;
    n_total++;
    if ({load_done, core_rst, load_err} !== 3'b100)
      $display("FAIL zero_len.status got %b want 100", {load_done, core_rst, load_err});
    else n_pass++;
  endtask

  task automatic test_backpressure();
    pulse_start();
    wr_n = 0;
    stream = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hD0};
    send_all(3);
    check_two_writes("backpressure");
    n_total++;
    if ({load_done, core_rst, load_err} !== 3'b100)
      $display("FAIL backpressure.status got %b want 100", {load_done, core_rst, load_err});
    else n_pass++;
  endtask

  task automatic test_reset_mid_data();
    pulse_start();
    stream = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13};
    send_all(0);
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({rx_ready, imem_we, core_rst, load_done, load_err, imem_waddr, imem_wdata} !== {5'b00100, 40'd0})
      $display("FAIL reset_mid.outputs got %b/%h/%h want 00100/0/0",
               {rx_ready, imem_we, core_rst, load_done, load_err}, imem_waddr, imem_wdata);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    wr_n  = 0;
    @(negedge clk);
    stream = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hD0};
    send_all(0);
    check_two_writes("reset_mid");
    n_total++;
    if (load_done !== 1'b1) $display("FAIL reset_mid.done got %b want 1", load_done); else n_pass++;
  endtask

  task automatic test_rearm();
    pulse_start();
    n_total++;
    if ({core_rst, load_done, rx_ready} !== 3'b101)
      $display("FAIL rearm.status got %b want 101", {core_rst, load_done, rx_ready});
    else n_pass++;
    wr_n = 0;
    send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'hEF, 0); send_byte(8'hBE, 0);
    pulse_start();
    n_total++;
    if ({rx_ready, load_done, load_err} !== 3'b100)
      $display("FAIL rearm.start_in_data got %b want 100", {rx_ready, load_done, load_err});
    else n_pass++;
    send_byte(8'hAD, 0); send_byte(8'hDE, 0); send_byte(8'h22, 0);
    n_total++;
    if (wr_n !== 1 || {wr_addr[0], wr_data[0]} !== {8'd0, 32'hDEAD_BEEF})
      $display("FAIL rearm.write got %0d:%h/%h want 1:00/deadbeef", wr_n, wr_addr[0], wr_data[0]);
    else n_pass++;
    n_total++;
    if ({load_done, core_rst, load_err} !== 3'b100)
      $display("FAIL rearm.run got %b want 100", {load_done, core_rst, load_err});
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_two_word();
    test_bad_checksum();
    test_oversize();
    test_zero_len();
    test_backpressure();
    test_reset_mid_data();
    test_rearm();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader that sits directly upstream of the five-stage RISC-V core.
- Accepts a byte stream over a valid/ready handshake, normally from a UART RX.
- Packs the bytes little-endian into 32-bit instructions and writes them into instruction memory through a dedicated write port.
- Holds the core's PC reset asserted until a complete, checksum-verified image is in memory, then releases the core to fetch from address 0.

Parameters:
- IMEM_DEPTH, 256: instruction memory depth in 32-bit words.
- ADDR_W, 8: word-address width; must satisfy 2**ADDR_W >= IMEM_DEPTH.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rx_valid  in  1  byte available on rx_data.
- rx_data  in  8  stream byte.
- rx_ready  out  1  loader can accept a byte; a transfer occurs when rx_valid && rx_ready.
- start  in  1  single-cycle re-arm pulse; honoured only in RUN or ERR.
- imem_we  out  1  instruction-memory write strobe, one cycle per word.
- imem_waddr  out  ADDR_W  word address (byte address >> 2).
- imem_wdata  out  32  instruction word.
- core_rst  out  1  active-high hold; drives the core's PC reset.
- load_done  out  1  level; image loaded and verified.
- load_err  out  1  level; length or checksum failure.

Behaviour:
- Stream format:
  - LEN_LO, then LEN_HI: 16-bit word count N.
  - N*4 payload bytes, each word least-significant byte first.
  - One checksum byte: XOR of all payload bytes. Length bytes are excluded.
- Reset values: rx_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0, core_rst=1, load_done=0, load_err=0.
- After reset deassertion the FSM is in LEN0.
- States and transitions:
  - LEN0: accept a byte into len[7:0] -> LEN1.
  - LEN1: accept a byte into len[15:8]. If len > IMEM_DEPTH -> ERR. If len == 0 -> CHK. Otherwise -> DATA.
  - DATA: accept payload bytes. Byte lane counter 0..3; word counter 0..N-1. Running XOR updates on every accepted payload byte. When lane 3 is accepted, the assembled word is presented. When the last byte of word N-1 is accepted -> CHK.
  - CHK: accept one byte. If equal to the running XOR -> RUN, otherwise -> ERR.
  - RUN: rx_ready=0; stream bytes are not consumed. start -> LEN0.
  - ERR: rx_ready=0. start -> LEN0.
- rx_ready:
  - Registered; equals 1 in LEN0, LEN1, DATA and CHK, otherwise 0.
  - Goes 1 on the first cycle after reset release.
- Write latency:
  - imem_we pulses exactly one cycle after the handshake that delivered lane 3.
  - In that same cycle imem_waddr = word index and imem_wdata = {b3,b2,b1,b0}.
  - Back-to-back words are separated by at least 4 handshake cycles, so writes never overlap.
- Registered status outputs:
  - core_rst = 0 only while in RUN; it falls the cycle after the CHK->RUN transition.
  - load_done = 1 only in RUN.
  - load_err = 1 only in ERR.
- Re-arm: on start in RUN or ERR:
  - Next cycle core_rst=1, load_done=0, load_err=0.
  - Counters and checksum are cleared and the FSM is in LEN0.
  - start in any other state is ignored.
- Counter widths and addressing:
  - Word counter is ADDR_W+1 bits. The length check guarantees it never exceeds IMEM_DEPTH, so the address never wraps.
  - A word is written to its address as soon as it completes. On ERR, words already written remain in memory and the core stays in reset.
- rx_valid without rx_ready has no effect; data may change freely between handshakes.
- rst_n asserted mid-operation: all outputs return to their reset values immediately (asynchronously). Partial memory contents are not cleared; the next load overwrites them.

Decomposition:
- Shared package holds:
  - the state enum (LEN0, LEN1, DATA, CHK, RUN, ERR);
  - the constant LEN_BYTES=2;
  - the checksum width CHK_W=8.
- One natural sub-module, imem_word_packer:
  - the lane counter and 4-byte shift/assemble register;
  - emits word_valid and word.
- Top level keeps the FSM, the word counter, the checksum and the output registers.

Test Plan:
- Two-word load:
  - Stimulus: bytes 02 00 93 00 50 00 13 00 00 00 D0.
  - Required: imem writes (0,0x00500093) then (1,0x00000013); load_done=1; core_rst=0; rx_ready=0.
- Bad checksum:
  - Stimulus: same stream with final byte D1.
  - Required: load_err=1, core_rst=1, load_done=0; the two writes still occurred.
- Oversize length:
  - Stimulus: 01 01 (N=257, IMEM_DEPTH=256).
  - Required: ERR on the cycle after LEN_HI; no imem_we; rx_ready=0.
- Zero length with backpressure:
  - Zero length: stream 00 00 00 -> RUN with no writes.
  - Backpressure: repeat the two-word load with rx_valid toggled randomly -> identical write sequence and checksum result.
- Reset mid-DATA:
  - Stimulus: assert rst_n=0 after 5 payload bytes.
  - Required: outputs immediately return to reset values. A fresh two-word load then succeeds, with address 0 written first.
- Re-arm:
  - Stimulus: start pulse in RUN.
  - Required: next cycle core_rst=1, load_done=0, rx_ready=1. A new image with N=1, word 0xDEADBEEF, checksum 0x22 -> write (0,0xDEADBEEF) and RUN.
  - Also check: start during DATA is ignored.
